// File: rtl/dmem_if.sv
// Load/store request and response channel between the MEM stage and the data-memory responder.
interface dmem_if #(
    parameter int unsigned ADDR_W = 12
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_mode;
    logic              req_signext;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    // MEM-stage initiator side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_mode, req_signext, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Memory responder side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_mode, req_signext, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a one-request-at-a-time valid/ready
// handshake, with byte/halfword lane select and sign/zero extension on loads.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- misaligned half/word accesses report
// rsp_err instead of silently clearing the low address bits.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 1
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    localparam int unsigned     Depth   = 2 ** (ADDR_W - 2);
    localparam int unsigned     CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        mode_q, mode_d;
    logic              signext_q, signext_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem [Depth];

    logic              is_half, is_byte, misalign, access_now, mem_we;
    logic [ADDR_W-3:0] word_idx;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, rd_word, load_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign is_half  = (mode_q == 2'b01);
    assign is_byte  = (mode_q == 2'b10);
    assign word_idx = addr_q[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    // Reserved mode decodes as word, so it traps like a word access.
    assign misalign = (is_half && addr_q[0]) ||
                      (!is_half && !is_byte && (addr_q[1:0] != 2'b00));
`else
    // Word index already drops addr[1:0]; the half lane uses only addr[1].
    assign misalign = 1'b0;
`endif

    assign access_now = (state_q == StAccess) && (cnt_q == '0);
    assign mem_we     = access_now && we_q && !misalign;

    // Lane decode: write byte-enables/replicated store data and extended load data.
    always_comb begin
        rd_word    = mem[word_idx];
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        load_data  = rd_word;
        byte_sel   = rd_word[{addr_q[1:0], 3'b000} +: 8];
        half_sel   = rd_word[{addr_q[1], 4'b0000} +: 16];
        if (is_byte) begin
            lane_be    = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{wdata_q[7:0]}};
            load_data  = {{24{signext_q & byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata_q[15:0]}};
            load_data  = {{16{signext_q & half_sel[15]}}, half_sel};
        end
    end

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mode_d      = mode_q;
        signext_d   = signext_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d      = bus.req_we;
                    addr_d    = bus.req_addr;
                    wdata_d   = bus.req_wdata;
                    mode_d    = bus.req_mode;
                    signext_d = bus.req_signext;
                    cnt_d     = CntInit;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = misalign;
                    rsp_data_d  = (we_q || misalign) ? 32'h0 : load_data;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            mode_q      <= 2'b00;
            signext_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mode_q      <= mode_d;
            signext_q   <= signext_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM lane writes; contents survive reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_be[k]) begin
                    mem[word_idx][8*k +: 8] <= lane_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected responses are queued when a request is
// accepted and compared when the response appears.
module tb_dmem_responder;

    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(12)) bus ();

    dmem_responder #(
        .ADDR_W  (12),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Garbage on the request bus after acceptance must not affect the operation.
    task automatic scramble_req();
        bus.req_we      = 1'($urandom);
        bus.req_addr    = 12'($urandom);
        bus.req_wdata   = $urandom;
        bus.req_mode    = 2'($urandom);
        bus.req_signext = 1'($urandom);
    endtask

    task automatic transact(input string tag, input logic we, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [1:0] mode, input logic sx,
                            input logic [31:0] exp_data, input logic exp_err, input int hold);
        int   cyc;
        rsp_t exp_r;
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_we      = we;
        bus.req_addr    = addr;
        bus.req_wdata   = wd;
        bus.req_mode    = mode;
        bus.req_signext = sx;
        bus.req_valid   = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble_req();
        sb_q.push_back('{data: exp_data, err: exp_err});
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(LAT));
        exp_r = sb_q.pop_front();
        chk({tag, ".data"}, bus.rsp_data, exp_r.data);
        chk({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_r.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, ".hold_data"}, bus.rsp_data, exp_r.data);
            chk({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, ".drop_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".drop_data"}, bus.rsp_data, 32'h0);
        chk({tag, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Accept a store, then hold rst for one edge rst_after edges later.
    task automatic abort_store(input string tag, input logic [11:0] addr, input logic [31:0] wd,
                               input int rst_after);
        bus.req_we      = 1'b1;
        bus.req_addr    = addr;
        bus.req_wdata   = wd;
        bus.req_mode    = 2'b00;
        bus.req_signext = 1'b0;
        bus.req_valid   = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (rst_after) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".rsp_data"}, bus.rsp_data, 32'h0);
        chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        repeat (LAT + 1) begin
            @(posedge clk); #1;
        end
        chk({tag, ".no_rsp"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_mode    = 2'b00;
        bus.req_signext = 1'b0;
        bus.rsp_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset.rsp_data", bus.rsp_data, 32'h0);
        chk("reset.rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset.req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store/load
        transact("st_w010", 1'b1, 12'h010, 32'h8765_4321, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        transact("ld_w010", 1'b0, 12'h010, 32'h0, 2'b00, 1'b0, 32'h8765_4321, 1'b0, 0);

        // Byte store into lane 1, byte loads with both extensions
        transact("st_b011", 1'b1, 12'h011, 32'h1234_56F0, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        transact("ld_w010b", 1'b0, 12'h010, 32'h0, 2'b00, 1'b0, 32'h8765_F021, 1'b0, 0);
        transact("ld_b011s", 1'b0, 12'h011, 32'h0, 2'b10, 1'b1, 32'hFFFF_FFF0, 1'b0, 0);
        transact("ld_b011z", 1'b0, 12'h011, 32'h0, 2'b10, 1'b0, 32'h0000_00F0, 1'b0, 0);
        transact("ld_b013s", 1'b0, 12'h013, 32'h0, 2'b10, 1'b1, 32'hFFFF_FF87, 1'b0, 0);

        // Half store into upper lane, half loads
        transact("st_w020", 1'b1, 12'h020, 32'h1234_5678, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        transact("st_h022", 1'b1, 12'h022, 32'h5555_BEEF, 2'b01, 1'b0, 32'h0, 1'b0, 0);
        transact("ld_w020", 1'b0, 12'h020, 32'h0, 2'b00, 1'b0, 32'hBEEF_5678, 1'b0, 0);
        transact("ld_h022s", 1'b0, 12'h022, 32'h0, 2'b01, 1'b1, 32'hFFFF_BEEF, 1'b0, 0);
        transact("ld_h022z", 1'b0, 12'h022, 32'h0, 2'b01, 1'b0, 32'h0000_BEEF, 1'b0, 0);
        transact("ld_h020s", 1'b0, 12'h020, 32'h0, 2'b01, 1'b1, 32'h0000_5678, 1'b0, 0);

        // Back-pressure, and reserved mode behaving as word
        transact("ld_hold", 1'b0, 12'h010, 32'h0, 2'b00, 1'b0, 32'h8765_F021, 1'b0, 5);
        transact("ld_mode3", 1'b0, 12'h010, 32'h0, 2'b11, 1'b1, 32'h8765_F021, 1'b0, 0);

        // Reset during ACCESS and exactly on the write edge
        transact("st_w030", 1'b1, 12'h030, 32'h1122_3344, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        abort_store("abort_mid", 12'h030, 32'hDEAD_BEEF, 1);
        abort_store("abort_wr", 12'h030, 32'hDEAD_BEEF, 2);
        transact("ld_w030", 1'b0, 12'h030, 32'h0, 2'b00, 1'b0, 32'h1122_3344, 1'b0, 0);

        // Misaligned word store
        transact("st_w040", 1'b1, 12'h040, 32'h5566_7788, 2'b00, 1'b0, 32'h0, 1'b0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        transact("st_w041", 1'b1, 12'h041, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0, 1'b1, 0);
        transact("ld_w040", 1'b0, 12'h040, 32'h0, 2'b00, 1'b0, 32'h5566_7788, 1'b0, 0);
        transact("ld_h023", 1'b0, 12'h023, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1, 0);
`else
        transact("st_w041", 1'b1, 12'h041, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        transact("ld_w040", 1'b0, 12'h040, 32'h0, 2'b00, 1'b0, 32'hCAFE_F00D, 1'b0, 0);
        transact("ld_h023", 1'b0, 12'h023, 32'h0, 2'b01, 1'b1, 32'hFFFF_BEEF, 1'b0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
